gamepad_pmod_tx: RTL and testbench
==================================

Name: gamepad_pmod_tx

Overview:
Transmitter side of the game-controller link that tinyQV samples on game_latch, game_clk and game_data. The block serialises two 12-bit SNES-style button words into one latch-plus-24-clock frame. It serves as an on-chip loopback source for the game peripheral and as the basis for a controller-emulation PMOD. One clock domain; all outputs are registered.

Parameters:
CLK_DIV, 4, half-period of game_clk and latch pulse width, in clk cycles (H); legal 1..255.
AUTO_PERIOD, 0, 0 = frames start only on start; >0 = internal trigger every AUTO_PERIOD clk cycles (must be > 49*CLK_DIV+1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle frame request; honoured only when busy=0
buttons_1  input  12  controller 1 buttons, active-high, bit 11 = B ... bit 0 = R
buttons_2  input  12  controller 2 buttons, same encoding
present_1  input  1  controller 1 connected; 0 forces its 12 bits to 0
present_2  input  1  controller 2 connected; 0 forces its 12 bits to 0
game_latch  output  1  latch pulse to receiver
game_clk  output  1  shift clock to receiver; receiver samples on rising edge
game_data  output  1  serial data, MSB first
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (asynchronous, immediate, including mid-frame): game_latch=0, game_clk=0, game_data=0, busy=0, frame_done=0, shift register=0, phase counter=0, bit counter=0, auto counter=0, state=IDLE.
- Trigger = start OR auto_tick. auto_tick pulses for one cycle when the free-running auto counter (0..AUTO_PERIOD-1, counting from reset) wraps. A trigger while busy=1 is dropped, not queued.
- Frame word W[23:0] = {present_1 ? buttons_1 : 0, present_2 ? buttons_2 : 0}, captured on the trigger edge. Input changes after capture do not affect the frame.
- Timing, with edge 0 = clock edge sampling the trigger:
  - after edge 0: state LATCH; busy=1, game_latch=1, game_data=W[23].
  - after edge H: state CLK_LO; game_latch=0, game_clk=0.
  - rising edge k (k=1..24) of game_clk after edge 2kH (CLK_HI); falling edge after edge (2k+1)H.
  - At each falling edge for k<24: shift left, so game_data = next bit. Bit W[24-k] is stable from the falling edge before rising edge k until the falling edge after it.
  - After edge 49H: state DONE; game_clk=0, game_data=0, busy=0, frame_done=1 for exactly one cycle, then IDLE.
- A trigger sampled at edge 49H+1 is accepted, so back-to-back frames are allowed with 1 idle cycle.
- game_latch and game_clk are never high at the same time. game_data changes only while game_clk=0.
- Phase counter counts 0..H-1 and advances the state on H-1. Bit counter counts 0..23 falling edges.
- CLK_DIV=1 is legal: each phase is 1 cycle and the frame is 49 cycles.
- frame_done and busy are never both 1.

Test Plan:
- CLK_DIV=4, buttons_1=12'hA5C, buttons_2=12'h3F1, both present, start pulse -> game_latch high for 4 cycles. Then 24 rising edges of game_clk, each 8 cycles apart. Bits sampled on rising edges = 24'hA5C3F1 MSB first. busy high for 196 cycles, then frame_done=1 for one cycle.
- present_2=0, buttons_2=12'hFFF, buttons_1=12'h001 -> sampled word 24'h001000.
- Start held high continuously, AUTO_PERIOD=0 -> frames back-to-back with exactly one idle cycle between frame_done and the next game_latch rise. No extra frame is triggered during busy.
- Change buttons_1 from 12'h000 to 12'hFFF at rising edge 3 -> frame still sampled as 24'h000xxx. The next frame carries 12'hFFF.
- AUTO_PERIOD=300, CLK_DIV=2, start tied 0 -> game_latch rises every 300 cycles. Each frame lasts 98 busy cycles.
- Assert rst_n=0 during bit 10 -> all outputs 0 asynchronously. After release, no activity until the next trigger, and that frame is complete and correct.

Source files
------------

// File: rtl/gamepad_pmod_tx.sv
// gamepad_pmod_tx: serialises two 12-bit SNES button words into one latch + 24-clock frame
module gamepad_pmod_tx #(
  parameter int CLK_DIV     = 4,
  parameter int AUTO_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] buttons_1,
  input  logic [11:0] buttons_2,
  input  logic        present_1,
  input  logic        present_2,
  output logic        game_latch,
  output logic        game_clk,
  output logic        game_data,
  output logic        busy,
  output logic        frame_done
);
  typedef enum logic [2:0] {IDLE, LATCH, CLK_LO, CLK_HI, DONE} state_t;
  localparam int AW = AUTO_PERIOD > 1 ? $clog2(AUTO_PERIOD) : 1;
  state_t      state, state_n;
  logic [7:0]  phase, phase_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [23:0] sr, sr_n;
  logic [23:0] word;
  logic [AW-1:0] auto_cnt;
  logic        auto_tick, trig, ph_end;
  assign auto_tick = (AUTO_PERIOD > 0) && (auto_cnt == AW'(AUTO_PERIOD - 1));
  assign trig      = start | auto_tick;
  assign ph_end    = phase == 8'(CLK_DIV - 1);
  assign word      = {present_1 ? buttons_1 : 12'h000, present_2 ? buttons_2 : 12'h000};
  assign game_data = sr[23];
  // free-running auto-trigger counter, wraps at AUTO_PERIOD-1 (held at 0 when disabled)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) auto_cnt <= '0;
    else auto_cnt <= (auto_tick || AUTO_PERIOD == 0) ? '0 : auto_cnt + 1'b1;
  // next-state: the DONE cycle accepts a trigger so frames can run with one idle cycle
  always_comb begin
    state_n   = state;
    phase_n   = ph_end ? '0 : phase + 8'd1;
    bit_cnt_n = bit_cnt;
    sr_n      = sr;
    case (state)
      IDLE, DONE: begin
        state_n   = trig ? LATCH : IDLE;
        phase_n   = '0;
        bit_cnt_n = '0;
        sr_n      = trig ? word : '0;
      end
      LATCH:  state_n = ph_end ? CLK_LO : LATCH;
      CLK_LO: state_n = ph_end ? CLK_HI : CLK_LO;
      CLK_HI: if (ph_end) begin
        state_n   = bit_cnt == 5'd23 ? DONE : CLK_LO;
        bit_cnt_n = bit_cnt + 5'd1;
        sr_n      = bit_cnt == 5'd23 ? '0 : {sr[22:0], 1'b0};
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counters, shift register and registered link outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      game_latch <= 1'b0;
      game_clk   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      bit_cnt    <= bit_cnt_n;
      sr         <= sr_n;
      game_latch <= state_n == LATCH;
      game_clk   <= state_n == CLK_HI;
      busy       <= state_n inside {LATCH, CLK_LO, CLK_HI};
      frame_done <= state_n == DONE;
    end
endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// tb_gamepad_pmod_tx: randomized frame checks against a word/timing model for three configurations
module tb_gamepad_pmod_tx;
  logic clk = 0, rst_n = 1, start = 0, start1 = 0;
  logic [11:0] buttons_1 = 0, buttons_2 = 0;
  logic present_1 = 1, present_2 = 1;
  logic game_latch, game_clk, game_data, busy, frame_done;
  logic d1_latch, d1_clk, d1_data, d1_busy, d1_done;
  logic da_latch, da_clk, da_data, da_busy, da_done;
  int sel = 0, nchk = 0, nfail = 0, cyc = 0;
  logic [4:0] o0, o1, o2, m;
  logic m_latch, m_clk, m_data, m_busy, m_done;

  gamepad_pmod_tx #(.CLK_DIV(4), .AUTO_PERIOD(0)) dut (.clk(clk), .rst_n(rst_n), .start(start),
    .buttons_1(buttons_1), .buttons_2(buttons_2), .present_1(present_1), .present_2(present_2),
    .game_latch(game_latch), .game_clk(game_clk), .game_data(game_data), .busy(busy), .frame_done(frame_done));
  gamepad_pmod_tx #(.CLK_DIV(1), .AUTO_PERIOD(0)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1),
    .buttons_1(buttons_1), .buttons_2(buttons_2), .present_1(present_1), .present_2(present_2),
    .game_latch(d1_latch), .game_clk(d1_clk), .game_data(d1_data), .busy(d1_busy), .frame_done(d1_done));
  gamepad_pmod_tx #(.CLK_DIV(2), .AUTO_PERIOD(300)) duta (.clk(clk), .rst_n(rst_n), .start(1'b0),
    .buttons_1(buttons_1), .buttons_2(buttons_2), .present_1(present_1), .present_2(present_2),
    .game_latch(da_latch), .game_clk(da_clk), .game_data(da_data), .busy(da_busy), .frame_done(da_done));

  assign o0 = {game_latch, game_clk, game_data, busy, frame_done};
  assign o1 = {d1_latch, d1_clk, d1_data, d1_busy, d1_done};
  assign o2 = {da_latch, da_clk, da_data, da_busy, da_done};
  assign m  = sel == 0 ? o0 : sel == 1 ? o1 : o2;
  assign {m_latch, m_clk, m_data, m_busy, m_done} = m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [23:0] exp_word(input logic [11:0] b1, b2, input logic p1, p2);
    return {p1 ? b1 : 12'h000, p2 ? b2 : 12'h000};
  endfunction

  function automatic string shape(input int h, bsy, rises, bad);
    return $sformatf("latch=%0d busy=%0d rises=%0d viol=%0d", h, bsy, rises, bad);
  endfunction

  task automatic randomize_inputs();
    buttons_1 = 12'($urandom_range(0, 4095));
    buttons_2 = 12'($urandom_range(0, 4095));
    present_1 = 1'($urandom_range(0, 1));
    present_2 = 1'($urandom_range(0, 1));
  endtask

  task automatic go(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1; else start = 1;
    @(negedge clk);
    start1 = 0;
    start = 0;
  endtask

  // observes one frame from its first latch-high sample until frame_done (bounded)
  task automatic watch(input int h, input int chg_at, output logic [23:0] w, output string s);
    int lat, bsy, rises, bad, last;
    logic pc, pd;
    w = 0; lat = 0; bsy = 0; rises = 0; bad = 0; last = -1; pc = 0; pd = m_data;
    for (int c = 0; c < 2000 && !m_done; c++) begin
      if (m_latch) lat++;
      if (m_busy) bsy++;
      if (m_latch && m_clk) bad++;
      if (m_clk && m_data !== pd) bad++;
      if (m_clk && !pc) begin
        rises++;
        w = {w[22:0], m_data};
        if (last >= 0 && c - last != 2 * h) bad++;
        last = c;
        if (rises == chg_at) buttons_1 = 12'hFFF;
      end
      pc = m_clk;
      pd = m_data;
      @(negedge clk);
    end
    if (m_busy) bad++;
    s = shape(lat, bsy, rises, bad);
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #1;
    nchk++;
    if ({o0, o1, o2} !== 15'd0) begin nfail++; $display("FAIL reset_outputs got=%b want=0", {o0, o1, o2}); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    nchk++;
    if (o0 !== 5'd0) begin nfail++; $display("FAIL idle_after_reset got=%b want=00000", o0); end
  endtask

  task automatic test_frame();
    logic [23:0] w;
    string s;
    sel = 0; buttons_1 = 12'hA5C; buttons_2 = 12'h3F1; present_1 = 1; present_2 = 1;
    go(0);
    watch(4, 0, w, s);
    nchk++;
    if (w !== 24'hA5C3F1) begin nfail++; $display("FAIL frame_word got=%h want=a5c3f1", w); end
    nchk++;
    if (s != shape(4, 196, 24, 0)) begin nfail++; $display("FAIL frame_shape got=%s want=%s", s, shape(4, 196, 24, 0)); end
    nchk++;
    if ({m_done, m_busy, m_clk, m_data} !== 4'b1000) begin nfail++; $display("FAIL frame_done got=%b want=1000", {m_done, m_busy, m_clk, m_data}); end
    @(negedge clk);
    nchk++;
    if ({m_done, m_busy, m_latch} !== 3'b000) begin nfail++; $display("FAIL done_pulse_width got=%b want=000", {m_done, m_busy, m_latch}); end
  endtask

  task automatic test_random();
    logic [23:0] w, e;
    string s;
    sel = 0;
    for (int i = 0; i < 8; i++) begin
      randomize_inputs();
      e = exp_word(buttons_1, buttons_2, present_1, present_2);
      go(0);
      watch(4, 0, w, s);
      nchk++;
      if (w !== e) begin nfail++; $display("FAIL random_word[%0d] got=%h want=%h", i, w, e); end
      nchk++;
      if (s != shape(4, 196, 24, 0)) begin nfail++; $display("FAIL random_shape[%0d] got=%s", i, s); end
    end
  endtask

  task automatic test_present();
    logic [23:0] w;
    string s;
    sel = 0; buttons_1 = 12'h001; buttons_2 = 12'hFFF; present_1 = 1; present_2 = 0;
    go(0);
    watch(4, 0, w, s);
    nchk++;
    if (w !== 24'h001000) begin nfail++; $display("FAIL present_mask got=%h want=001000", w); end
    present_2 = 1;
  endtask

  task automatic test_capture();
    logic [23:0] w;
    logic [11:0] b2;
    string s;
    sel = 0; present_1 = 1; present_2 = 1; buttons_1 = 12'h000;
    b2 = 12'($urandom_range(0, 4095));
    buttons_2 = b2;
    go(0);
    watch(4, 3, w, s);
    nchk++;
    if (w !== {12'h000, b2}) begin nfail++; $display("FAIL capture_hold got=%h want=%h", w, {12'h000, b2}); end
    go(0);
    watch(4, 0, w, s);
    nchk++;
    if (w !== {12'hFFF, b2}) begin nfail++; $display("FAIL capture_next got=%h want=%h", w, {12'hFFF, b2}); end
  endtask

  task automatic test_div1();
    logic [23:0] w, e;
    string s;
    sel = 1;
    randomize_inputs();
    e = exp_word(buttons_1, buttons_2, present_1, present_2);
    go(1);
    watch(1, 0, w, s);
    nchk++;
    if (w !== e) begin nfail++; $display("FAIL div1_word got=%h want=%h", w, e); end
    nchk++;
    if (s != shape(1, 49, 24, 0)) begin nfail++; $display("FAIL div1_shape got=%s want=%s", s, shape(1, 49, 24, 0)); end
    sel = 0;
  endtask

  task automatic test_back_to_back();
    logic [23:0] w, e;
    string s;
    sel = 0;
    randomize_inputs();
    e = exp_word(buttons_1, buttons_2, present_1, present_2);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      watch(4, 0, w, s);
      nchk++;
      if (w !== e || s != shape(4, 196, 24, 0)) begin nfail++; $display("FAIL b2b_frame[%0d] got=%h %s want=%h", f, w, s, e); end
      if (f == 2) start = 0;
      else begin
        randomize_inputs();
        e = exp_word(buttons_1, buttons_2, present_1, present_2);
      end
      @(negedge clk);
      nchk++;
      if ({m_latch, m_busy} !== (f < 2 ? 2'b11 : 2'b00)) begin nfail++; $display("FAIL b2b_gap[%0d] got=%b want=%b", f, {m_latch, m_busy}, f < 2 ? 2'b11 : 2'b00); end
    end
  endtask

  task automatic test_auto();
    logic [23:0] w, e;
    string s;
    logic pl;
    int t0;
    sel = 2; present_1 = 1; present_2 = 1;
    buttons_1 = 12'($urandom_range(0, 4095));
    buttons_2 = 12'($urandom_range(0, 4095));
    e = {buttons_1, buttons_2};
    t0 = -1;
    for (int fr = 0; fr < 3; fr++) begin
      pl = 1;
      for (int i = 0; i < 700 && !(m_latch && !pl); i++) begin pl = m_latch; @(negedge clk); end
      nchk++;
      if (!m_latch) begin nfail++; $display("FAIL auto_rise[%0d] got=no_latch want=latch", fr); end
      if (fr > 0) begin
        nchk++;
        if (cyc - t0 != 300) begin nfail++; $display("FAIL auto_period[%0d] got=%0d want=300", fr, cyc - t0); end
      end
      t0 = cyc;
      watch(2, 0, w, s);
      nchk++;
      if (w !== e || s != shape(2, 98, 24, 0)) begin nfail++; $display("FAIL auto_frame[%0d] got=%h %s want=%h", fr, w, s, e); end
    end
    sel = 0;
  endtask

  task automatic test_async_reset();
    logic [23:0] w, e;
    string s;
    logic pc;
    int r, act;
    sel = 0;
    randomize_inputs();
    go(0);
    r = 0; pc = 0;
    for (int i = 0; i < 400 && r < 10; i++) begin
      if (m_clk && !pc) r++;
      pc = m_clk;
      if (r < 10) @(negedge clk);
    end
    #2 rst_n = 0;
    #1;
    nchk++;
    if (o0 !== 5'd0) begin nfail++; $display("FAIL async_reset got=%b want=00000", o0); end
    @(negedge clk);
    rst_n = 1;
    act = 0;
    for (int i = 0; i < 60; i++) begin
      if (o0 !== 5'd0) act++;
      @(negedge clk);
    end
    nchk++;
    if (act != 0) begin nfail++; $display("FAIL post_reset_quiet got=%0d want=0", act); end
    randomize_inputs();
    e = exp_word(buttons_1, buttons_2, present_1, present_2);
    go(0);
    watch(4, 0, w, s);
    nchk++;
    if (w !== e || s != shape(4, 196, 24, 0)) begin nfail++; $display("FAIL post_reset_frame got=%h %s want=%h", w, s, e); end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame();
    test_random();
    test_present();
    test_capture();
    test_div1();
    test_back_to_back();
    test_auto();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
